// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN neighbour-list blocks: vote FSM state
// encoding and the count/index width helper also used by the list core.
package knn_pkg;

  typedef enum logic [1:0] {
    KV_IDLE = 2'd0,
    KV_SCAN = 2'd1,
    KV_DONE = 2'd2
  } kv_state_t;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/knn_match_count.sv
// Combinational match counter: how many of the first k list slots hold the
// probe label. Kept standalone so a weighted-vote variant can reuse it.
module knn_match_count
  import knn_pkg::*;
#(
  parameter  int LABEL       = 8,
  parameter  int N_NEIGHBOUR = 10,
  localparam int CNT_W       = cnt_width(N_NEIGHBOUR)
) (
  input  logic [LABEL*N_NEIGHBOUR-1:0] lab,
  input  logic [LABEL-1:0]             probe,
  input  logic [CNT_W-1:0]             k,
  output logic [CNT_W-1:0]             cnt
);

  // Masked equality compare per slot, summed into a popcount.
  always_comb begin
    // NOTE: a default before any conditional update keeps this block free of inferred latches.
    cnt = '0;
    for (int j = 0; j < N_NEIGHBOUR; j++) begin
      if ((CNT_W'(j) < k) && (lab[j*LABEL +: LABEL] == probe)) begin
        cnt = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/knn_vote.sv
// Majority-vote reader for the k-NN neighbour list. Snapshots the label
// vector on start, scans one populated slot per cycle and reports the winning
// label and its vote count with a single-cycle done pulse.
module knn_vote
  import knn_pkg::*;
#(
  parameter  int LABEL       = 8,
  parameter  int N_NEIGHBOUR = 10,
  localparam int CNT_W       = cnt_width(N_NEIGHBOUR)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             n_valid,
  input  logic [LABEL*N_NEIGHBOUR-1:0] neighbour_info,
  output logic                         busy,
  output logic                         done,
  output logic [LABEL-1:0]             label_out,
  output logic [CNT_W-1:0]             votes_out
);

  kv_state_t state, state_d;

  logic [N_NEIGHBOUR-1:0][LABEL-1:0] lab_q, lab_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] best_cnt, best_cnt_d;
  logic [LABEL-1:0] best_lab, best_lab_d;
  logic [LABEL-1:0] probe;
  logic [CNT_W-1:0] cnt;

  // The probe is always taken from the snapshot, never from the live input.
  assign probe = lab_q[idx];

  knn_match_count #(
    .LABEL       (LABEL),
    .N_NEIGHBOUR (N_NEIGHBOUR)
  ) u_match (
    .lab   (lab_q),
    .probe (probe),
    .k     (k_q),
    .cnt   (cnt)
  );

  // Next-state and datapath updates: snapshot on start, strict-greater best tracking.
  always_comb begin
    state_d    = state;
    lab_d      = lab_q;
    k_d        = k_q;
    idx_d      = idx;
    best_cnt_d = best_cnt;
    best_lab_d = best_lab;
    unique case (state)
      KV_IDLE: begin
        if (start) begin
          lab_d      = neighbour_info;
          k_d        = (n_valid > CNT_W'(N_NEIGHBOUR)) ? CNT_W'(N_NEIGHBOUR) : n_valid;
          idx_d      = '0;
          best_cnt_d = '0;
          best_lab_d = '0;
          state_d    = (k_d == '0) ? KV_DONE : KV_SCAN;
        end
      end
      KV_SCAN: begin
        // Strict compare plus ascending scan makes the nearest label win ties.
        if (cnt > best_cnt) begin
          best_cnt_d = cnt;
          best_lab_d = probe;
        end
        idx_d = idx + CNT_W'(1);
        if (idx == k_q - CNT_W'(1)) begin
          state_d = KV_DONE;
        end
      end
      KV_DONE: state_d = KV_IDLE;
      default: state_d = KV_IDLE;
    endcase
  end

  // State, snapshot and registered outputs; results load on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KV_IDLE;
      // NOTE: the snapshot is reset too, so a reset mid-vote leaves no stale labels behind.
      lab_q     <= '0;
      k_q       <= '0;
      idx       <= '0;
      best_cnt  <= '0;
      best_lab  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      label_out <= '0;
      votes_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state    <= state_d;
      lab_q    <= lab_d;
      k_q      <= k_d;
      idx      <= idx_d;
      best_cnt <= best_cnt_d;
      best_lab <= best_lab_d;
      busy     <= (state_d != KV_IDLE);
      done     <= (state_d == KV_DONE);
      if (state_d == KV_DONE) begin
        label_out <= best_lab_d;
        votes_out <= best_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed scenarios plus a randomised
// comparison against an independent histogram-based majority model.
module tb_knn_vote;

  localparam int LABEL = 8;
  localparam int NN    = 10;
  localparam int CW    = 4;
  localparam int LIMIT = 20;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   n_valid;
  logic [LABEL*NN-1:0] neighbour_info;
  logic            busy;
  logic            done;
  logic [LABEL-1:0] label_out;
  logic [CW-1:0]   votes_out;

  int checks = 0;
  int errors = 0;

  knn_vote #(.LABEL(LABEL), .N_NEIGHBOUR(NN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .n_valid        (n_valid),
    .neighbour_info (neighbour_info),
    .busy           (busy),
    .done           (done),
    .label_out      (label_out),
    .votes_out      (votes_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LABEL*NN-1:0] pack(input logic [7:0] s [NN]);
    logic [LABEL*NN-1:0] v;
    v = '0;
    for (int i = 0; i < NN; i++) v[i*LABEL +: LABEL] = s[i];
    return v;
  endfunction

  // Reference: histogram of the first k labels, then the earliest slot whose
  // label reaches the maximum count wins.
  function automatic void model(input logic [LABEL*NN-1:0] info, input int n,
                                output logic [7:0] lab, output int votes);
    int hist [256];
    int k;
    int mx;
    logic found;
    k = (n > NN) ? NN : n;
    for (int v = 0; v < 256; v++) hist[v] = 0;
    for (int i = 0; i < k; i++) hist[info[i*LABEL +: LABEL]]++;
    mx = 0;
    for (int v = 0; v < 256; v++) if (hist[v] > mx) mx = hist[v];
    lab = 8'd0;
    votes = mx;
    found = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (!found && hist[info[i*LABEL +: LABEL]] == mx) begin
        lab = info[i*LABEL +: LABEL];
        found = 1'b1;
      end
    end
  endfunction

  // Issue one vote and wait (bounded) for done; lat counts cycles from the start cycle.
  task automatic run_vote(input logic [LABEL*NN-1:0] info, input int n, output int lat);
    neighbour_info = info;
    n_valid = CW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [7:0] s_major [NN] = '{8'd3, 8'd7, 8'd3, 8'd3, 8'd1, 8'd3, 8'd7, 8'd2, 8'd3, 8'd9};
  logic [7:0] s_tie   [NN] = '{8'd4, 8'd6, 8'd6, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] s_eight [NN] = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8};
  logic [7:0] s_five  [NN] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};

  task automatic test_reset();
    checks++;
    if ({busy, done, label_out, votes_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b label=%0d votes=%0d, required all 0",
               busy, done, label_out, votes_out);
    end
  endtask

  task automatic test_majority();
    int lat;
    neighbour_info = pack(s_major);
    n_valid = 4'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL major_busy: busy=%b, required 1", busy);
    end
    lat = 1;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL major_latency: got %0d, required 11", lat); end
    checks++;
    if (label_out !== 8'd3) begin errors++; $display("FAIL major_label: got %0d, required 3", label_out); end
    checks++;
    if (votes_out !== 4'd5) begin errors++; $display("FAIL major_votes: got %0d, required 5", votes_out); end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL major_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_tie();
    int lat;
    run_vote(pack(s_tie), 4, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL tie_latency: got %0d, required 5", lat); end
    checks++;
    if (label_out !== 8'd4) begin errors++; $display("FAIL tie_label: got %0d, required 4", label_out); end
    checks++;
    if (votes_out !== 4'd2) begin errors++; $display("FAIL tie_votes: got %0d, required 2", votes_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_clamp();
    int lat;
    run_vote(pack(s_major), 0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL empty_latency: got %0d, required 1", lat); end
    checks++;
    if ({label_out, votes_out} !== '0) begin
      errors++;
      $display("FAIL empty_result: got %0d/%0d, required 0/0", label_out, votes_out);
    end
    @(posedge clk); #1;
    run_vote(pack(s_eight), 15, lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL clamp_latency: got %0d, required 11", lat); end
    checks++;
    if (label_out !== 8'd8 || votes_out !== 4'd10) begin
      errors++;
      $display("FAIL clamp_result: got %0d/%0d, required 8/10", label_out, votes_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_snapshot();
    int n_done;
    neighbour_info = pack(s_major);
    n_valid = 4'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        neighbour_info = pack(s_five);
        n_valid = 4'd2;
        start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        n_done++;
        checks++;
        if (label_out !== 8'd3 || votes_out !== 4'd5) begin
          errors++;
          $display("FAIL snapshot_result: got %0d/%0d, required 3/5", label_out, votes_out);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL snapshot_done_count: got %0d, required 1", n_done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_vote(pack(s_tie), 4, lat);
    // start raised during the DONE cycle must be ignored
    neighbour_info = pack(s_eight);
    n_valid = 4'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored: busy=%b, required 0", busy); end
    run_vote(pack(s_major), 10, lat);
    checks++;
    if (lat !== 11 || label_out !== 8'd3 || votes_out !== 4'd5) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d %0d/%0d, required 11 3/5", lat, label_out, votes_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    run_vote(pack(s_major), 10, lat);
    @(posedge clk); #1;
    neighbour_info = pack(s_tie);
    n_valid = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, label_out, votes_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b %0d/%0d, required all 0",
               busy, done, label_out, votes_out);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vote(pack(s_tie), 4, lat);
    checks++;
    if (lat !== 5 || label_out !== 8'd4 || votes_out !== 4'd2) begin
      errors++;
      $display("FAIL reset_mid_recover: lat=%0d %0d/%0d, required 5 4/2", lat, label_out, votes_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] s [NN];
    logic [7:0] exp_lab;
    int exp_votes;
    int n;
    int k;
    int lat;
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NN; i++) s[i] = 8'($urandom_range(0, (t % 2) ? 3 : 255));
      n = $urandom_range(0, 15);
      k = (n > NN) ? NN : n;
      model(pack(s), n, exp_lab, exp_votes);
      run_vote(pack(s), n, lat);
      checks++;
      if (lat !== k + 1 || label_out !== exp_lab || votes_out !== CW'(exp_votes)) begin
        errors++;
        $display("FAIL random_%0d: n=%0d lat=%0d %0d/%0d, required lat=%0d %0d/%0d",
                 t, n, lat, label_out, votes_out, k + 1, exp_lab, exp_votes);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    n_valid = '0;
    neighbour_info = '0;
    #23;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_majority();
    test_tie();
    test_empty_clamp();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote reader for the k-NN neighbour list. It sits downstream of the distance/sorted-list core and consumes the packed `neighbour_info` label vector that the list writes. On a `start` pulse it snapshots the list and scans the populated entries one per cycle. It then reports the winning label and its vote count with a one-cycle `done` pulse, for the software-visible result register.

## Interface
Parameters:
- `LABEL`, 8: label width in bits.
- `N_NEIGHBOUR`, 10: number of list slots.
- `CNT_W`, `$clog2(N_NEIGHBOUR+1)`: width of counts and indices. Derived; not overridden.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a vote. Sampled only in IDLE.
- `n_valid`, input, `CNT_W`: number of populated slots. Values above `N_NEIGHBOUR` are clamped to `N_NEIGHBOUR`.
- `neighbour_info`, input, `LABEL*N_NEIGHBOUR`: packed labels. Slot i is `[i*LABEL +: LABEL]`; slot 0 is the nearest neighbour.
- `busy`, output, 1: a vote is in progress.
- `done`, output, 1: one-cycle pulse; the result is valid.
- `label_out`, output, `LABEL`: winning label. Held until the next `done`.
- `votes_out`, output, `CNT_W`: occurrences of `label_out` among the populated slots.

## Operation
State machine: IDLE, SCAN, DONE.
- **IDLE, on `start`:**
  - Register a copy of `neighbour_info` into `lab_q` and set `k = min(n_valid, N_NEIGHBOUR)`.
  - Clear `idx`, `best_cnt` and `best_lab`.
  - If `k==0`, go to DONE; otherwise go to SCAN.
- **SCAN, cycle with index `idx`:**
  - `cnt` = number of slots j < k with `lab_q[j] == lab_q[idx]`. This is combinational: `N_NEIGHBOUR` comparators masked by j<k, followed by a popcount.
  - If `cnt > best_cnt` (strictly greater), update `best_cnt` and `best_lab`.
  - Increment `idx`. After the scan at `idx == k-1`, go to DONE.
- **Tie rule:** the strict compare, combined with ascending scan order, makes the label whose nearest occurrence has the lowest slot index win.
- **DONE:**
  - `label_out` ← `best_lab`, `votes_out` ← `best_cnt`, assert `done`. For `k==0` the result is 0/0.
  - Return to IDLE.
- **`start` while not in IDLE:** ignored, not queued.
- **Input changes during a vote:** changes to `neighbour_info` or `n_valid` have no effect on it, because all scanning uses the snapshot.
- **Reset (including mid-vote):** asynchronous return to IDLE. `busy`, `done`, `label_out`, `votes_out`, `idx`, `best_*` and `lab_q` all go to 0.

## Timing
- `start` is sampled at edge t. `busy` is high from t+1 through the DONE cycle inclusive.
- SCAN occupies cycles t+1 … t+k. `done` is high in cycle t+k+1, and the results are registered on the same edge.
  - Latency is k+1 cycles; worst case is `N_NEIGHBOUR`+1.
  - For k==0, `done` is high at t+1.
- `start` is accepted again in the cycle after `done`, at the earliest. Back-to-back votes are separated by at least one IDLE cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- `knn_pkg` holds:
  - the state encoding constants (`KV_IDLE`, `KV_SCAN`, `KV_DONE`);
  - the `CNT_W` width function, shared with the list core for its `n_valid` counter.
- `knn_match_count` is a combinational sub-module. Its inputs are the snapshot, the probe label and `k`; its output is `cnt`. It is reusable by a future weighted-vote variant.
- `knn_vote` contains the FSM, snapshot, index counter and best-result registers.

## Test plan
All scenarios use `N_NEIGHBOUR=10` and `LABEL=8`.
- **Clear majority:**
  - Stimulus: slots = 3,7,3,3,1,3,7,2,3,9; `n_valid=10`; `start`.
  - Response: `done` 11 cycles after `start`; `label_out=3`, `votes_out=5`.
- **Tie resolved by nearest:**
  - Stimulus: slots = 4,6,6,4, rest 0; `n_valid=4`.
  - Response: `label_out=4`, `votes_out=2`, `done` at t+5. Unused zero slots are ignored.
- **Empty and clamp:**
  - `n_valid=0` → `done` at t+1, 0/0.
  - `n_valid=15` with all slots = 8 → `votes_out=10`.
- **Snapshot and ignored start:**
  - Stimulus: change `neighbour_info` to all 5s, and pulse `start`, both during SCAN of the first scenario.
  - Response: result is still 3/5; there is exactly one `done`.
- **Reset mid-scan:**
  - Stimulus: deassert `rst_n` (drive it low) asynchronously during SCAN.
  - Response: outputs are 0 immediately. A fresh `start` after release produces a correct result.
- **Randomised scoreboard:** 1000 random lists and `n_valid` values, checked against a reference majority model with the same tie rule.
